// File: rtl/fb_arbiter.sv
// Framebuffer port arbiter: shares one single-port RAM between raster reads and draw writes.
// Optional per-frame stall/force statistics are enabled by defining FB_ARB_STATS_EN.
module fb_arbiter #(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 12,
    parameter int RD_LAT       = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              vblank,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef FB_ARB_STATS_EN
    ,
    output logic [15:0]       stat_rd_stall,
    output logic [15:0]       stat_wr_stall,
    output logic [15:0]       stat_forced
`endif
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    // Handshake: a client holds req with stable addr/data until it sees gnt;
    // the transfer happens in the cycle where req && gnt, and a new request
    // may be raised in the cycle after gnt.

    logic              vblank_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              force_q, force_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [RD_LAT:0]   vld_q, vld_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              vblank_rise;
    logic              wr_wins;

    always_comb begin
        vblank_rise = vblank & ~vblank_q;
        // The force flag only matters in active video; vblank already favours writes.
        wr_wins     = vblank | force_q | ~rd_req;
        wr_gnt      = reset & wr_req & wr_wins;
        rd_gnt      = reset & rd_req & ~(wr_req & wr_wins);
    end

    always_comb begin
        cnt_d   = cnt_q;
        force_d = force_q;
        if (wr_gnt || !wr_req || vblank_rise) begin
            cnt_d   = '0;
            force_d = 1'b0;
        end else if (rd_gnt) begin
            if (cnt_q != LIMIT) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (cnt_d == LIMIT) begin
                force_d = 1'b1;
            end
        end
    end

    always_comb begin
        mem_en_d    = rd_gnt | wr_gnt;
        mem_we_d    = wr_gnt;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (wr_gnt) begin
            mem_addr_d  = wr_addr;
            mem_wdata_d = wr_data;
        end else if (rd_gnt) begin
            mem_addr_d  = rd_addr;
        end
        // Bit k set means a read command issued k cycles ago; the tail lines up with mem_rdata.
        vld_d      = {vld_q[RD_LAT-1:0], rd_gnt};
        rd_valid_d = vld_q[RD_LAT];
        rd_data_d  = vld_q[RD_LAT] ? mem_rdata : rd_data_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vblank_q    <= 1'b0;
            cnt_q       <= '0;
            force_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            vld_q       <= '0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            vblank_q    <= vblank;
            cnt_q       <= cnt_d;
            force_q     <= force_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            vld_q       <= vld_d;
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;

`ifdef FB_ARB_STATS_EN
    logic [15:0] run_rd_q, run_rd_d;
    logic [15:0] run_wr_q, run_wr_d;
    logic [15:0] run_fc_q, run_fc_d;
    logic [15:0] out_rd_q, out_rd_d;
    logic [15:0] out_wr_q, out_wr_d;
    logic [15:0] out_fc_q, out_fc_d;
    logic        ev_rd, ev_wr, ev_fc;

    function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic ev);
        sat_inc = (ev && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

    always_comb begin
        ev_rd    = rd_req & ~rd_gnt;
        ev_wr    = wr_req & ~wr_gnt;
        ev_fc    = wr_gnt & rd_req & force_q & ~vblank;
        out_rd_d = out_rd_q;
        out_wr_d = out_wr_q;
        out_fc_d = out_fc_q;
        run_rd_d = sat_inc(run_rd_q, ev_rd);
        run_wr_d = sat_inc(run_wr_q, ev_wr);
        run_fc_d = sat_inc(run_fc_q, ev_fc);
        // Frame boundary: publish the finished frame, then this cycle starts the new one.
        if (vblank_rise) begin
            out_rd_d = run_rd_q;
            out_wr_d = run_wr_q;
            out_fc_d = run_fc_q;
            run_rd_d = sat_inc(16'd0, ev_rd);
            run_wr_d = sat_inc(16'd0, ev_wr);
            run_fc_d = sat_inc(16'd0, ev_fc);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_rd_q <= '0;
            run_wr_q <= '0;
            run_fc_q <= '0;
            out_rd_q <= '0;
            out_wr_q <= '0;
            out_fc_q <= '0;
        end else begin
            run_rd_q <= run_rd_d;
            run_wr_q <= run_wr_d;
            run_fc_q <= run_fc_d;
            out_rd_q <= out_rd_d;
            out_wr_q <= out_wr_d;
            out_fc_q <= out_fc_d;
        end
    end

    assign stat_rd_stall = out_rd_q;
    assign stat_wr_stall = out_wr_q;
    assign stat_forced   = out_fc_q;
`endif

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter: RAM model, read-return scoreboard, priority and latency checks.
module tb_fb_arbiter;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 12;
  localparam int RD_LAT = 2;
  localparam int STARVE_LIMIT = 8;

  logic clock = 1'b0;
  logic reset;
  logic vblank;
  logic rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic rd_gnt;
  logic [DATA_W-1:0] rd_data;
  logic rd_valid;
  logic wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic wr_gnt;
  logic mem_en;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
`ifdef FB_ARB_STATS_EN
  logic [15:0] stat_rd_stall;
  logic [15:0] stat_wr_stall;
  logic [15:0] stat_forced;
`endif

  fb_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clock(clock), .reset(reset), .vblank(vblank),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef FB_ARB_STATS_EN
    , .stat_rd_stall(stat_rd_stall), .stat_wr_stall(stat_wr_stall), .stat_forced(stat_forced)
`endif
  );

  // clock / reset
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Deterministic RAM contents; reads never target written addresses.
  function automatic logic [DATA_W-1:0] mem_fn(input logic [ADDR_W-1:0] a);
    if (a[7:0] == 8'h23) return 12'hABC;
    return {a[3:0], a[7:0]} ^ 12'h5A5;
  endfunction

  logic [DATA_W-1:0] rpipe [RD_LAT];
  always @(posedge clock) begin
    rpipe[0] <= (mem_en && !mem_we) ? mem_fn(mem_addr) : '0;
    for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
  end
  assign mem_rdata = rpipe[RD_LAT-1];

  // scoreboard: push on read grant, pop on rd_valid
  always @(negedge clock) begin
    if (reset) begin
      if (rd_gnt) exp_q.push_back(mem_fn(rd_addr));
      if (rd_valid) begin
        if (exp_q.size() == 0) chk("sb_unexpected_valid", rd_valid, 0);
        else chk("sb_rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  int n_en, n_we, nv, first_v, last_v;

  initial begin
    reset = 1'b0; vblank = 1'b0;
    rd_req = 1'b1; wr_req = 1'b1;
    rd_addr = '0; wr_addr = '0; wr_data = '0;

    // reset with both requests high
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_rd_gnt", rd_gnt, 0);
    chk("rst_wr_gnt", wr_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_mem_addr", mem_addr, 0);
    next_cycle();
    rd_req = 1'b0; wr_req = 1'b0; reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("idle_mem_en", mem_en, 0);
    end

    // single read latency
    next_cycle();
    rd_req = 1'b1; rd_addr = 17'h00123;
    @(negedge clock);
    chk("lat_rd_gnt", rd_gnt, 1);
    chk("lat_wr_gnt", wr_gnt, 0);
    next_cycle();
    rd_req = 1'b0;
    @(negedge clock);
    chk("lat_mem_en", mem_en, 1);
    chk("lat_mem_we", mem_we, 0);
    chk("lat_mem_addr", mem_addr, 17'h00123);
    for (int k = 2; k < 4; k++) begin
      @(negedge clock);
      chk("lat_early_valid", rd_valid, 0);
    end
    @(negedge clock);
    chk("lat_rd_valid", rd_valid, 1);
    chk("lat_rd_data", rd_data, 12'hABC);
    @(negedge clock);
    chk("lat_valid_pulse", rd_valid, 0);
    chk("lat_data_hold", rd_data, 12'hABC);

    // starvation guard in active video
    next_cycle();
    rd_req = 1'b1; wr_req = 1'b1;
    rd_addr = 17'h00010; wr_addr = 17'h00050; wr_data = 12'h5A5;
    n_en = 0; n_we = 0;
    for (int i = 0; i < 27; i++) begin
      @(negedge clock);
      chk("starve_wr_gnt", wr_gnt, (i % 9) == 8);
      chk("starve_rd_gnt", rd_gnt, (i % 9) != 8);
      if (i > 0) begin
        n_en += int'(mem_en);
        n_we += int'(mem_we);
      end
    end
    next_cycle();
    rd_req = 1'b0; wr_req = 1'b0;
    @(negedge clock);
    n_en += int'(mem_en);
    n_we += int'(mem_we);
    chk("starve_cmds", n_en, 27);
    chk("starve_writes", n_we, 3);
    chk("starve_wr_addr", mem_addr, 17'h00050);
    chk("starve_wdata", mem_wdata, 12'h5A5);
    repeat (6) @(negedge clock);

    // lone write in active video is granted at once
    next_cycle();
    wr_req = 1'b1; wr_addr = 17'h00077; wr_data = 12'h123;
    @(negedge clock);
    chk("solo_wr_gnt", wr_gnt, 1);
    next_cycle();
    wr_req = 1'b0;
    @(negedge clock);
    chk("solo_mem_we", mem_we, 1);
    chk("solo_mem_addr", mem_addr, 17'h00077);
    chk("solo_mem_wdata", mem_wdata, 12'h123);

    // vblank: writes win every conflict
    next_cycle();
    vblank = 1'b1; rd_req = 1'b1; wr_req = 1'b1; rd_addr = 17'h00020;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("vb_wr_gnt", wr_gnt, 1);
      chk("vb_rd_gnt", rd_gnt, 0);
    end
    next_cycle();
    wr_req = 1'b0;
    @(negedge clock);
    chk("vb_rd_gnt_solo", rd_gnt, 1);
    chk("vb_wr_gnt_solo", wr_gnt, 0);
    next_cycle();
    rd_req = 1'b0; vblank = 1'b0;
    repeat (6) @(negedge clock);

    // back-to-back reads
    nv = 0; first_v = -1; last_v = -1;
    for (int c = 0; c < 24; c++) begin
      next_cycle();
      if (c < 16) begin
        rd_req = 1'b1;
        rd_addr = 17'h00100 + 17'(c);
      end else begin
        rd_req = 1'b0;
      end
      @(negedge clock);
      if (c < 16) chk("b2b_rd_gnt", rd_gnt, 1);
      if (rd_valid) begin
        nv++;
        if (first_v < 0) first_v = c;
        last_v = c;
      end
    end
    chk("b2b_count", nv, 16);
    chk("b2b_first", first_v, 4);
    chk("b2b_span", last_v - first_v, 15);

    // reset while reads are in flight, with the starvation counter non-zero
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      rd_req = 1'b1; wr_req = 1'b1;
      rd_addr = 17'h00030 + 17'(c); wr_addr = 17'h00060; wr_data = 12'h0F0;
      @(negedge clock);
      chk("mf_rd_gnt", rd_gnt, 1);
    end
    next_cycle();
    reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    chk("mf_rst_rd_gnt", rd_gnt, 0);
    chk("mf_rst_wr_gnt", wr_gnt, 0);
    chk("mf_rst_mem_en", mem_en, 0);
    chk("mf_rst_rd_valid", rd_valid, 0);
    next_cycle();
    rd_req = 1'b0; wr_req = 1'b0;
    next_cycle();
    reset = 1'b1;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      nv += int'(rd_valid);
    end
    chk("mf_no_return", nv, 0);
    chk("mf_rd_data", rd_data, 0);
`ifdef FB_ARB_STATS_EN
    chk("mf_stat_rd", stat_rd_stall, 0);
    chk("mf_stat_wr", stat_wr_stall, 0);
    chk("mf_stat_fc", stat_forced, 0);
`endif
    // counter restarted from zero: full 8 reads before the forced write
    next_cycle();
    rd_req = 1'b1; wr_req = 1'b1; rd_addr = 17'h00040;
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      chk("mf_cnt_wr_gnt", wr_gnt, i == 8);
    end
    next_cycle();
    rd_req = 1'b0; wr_req = 1'b0;
    repeat (8) @(negedge clock);
    chk("sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
